// File: rtl/systolic_feeder_if.sv
// Operand-load, run-control and skewed lane signals between a host and systolic_feeder.
interface systolic_feeder_if #(
  parameter int unsigned N = 2,
  parameter int unsigned K = 4
);
  localparam int unsigned NK = N * K;
  localparam int unsigned AW = (NK > 1) ? $clog2(NK) : 1;
  localparam int unsigned KW = $clog2(K + 1);

  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [KW-1:0] k_len;
  logic [N*8-1:0] a_out;
  logic [N*8-1:0] b_out;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, k_len,
    input  a_out, b_out, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, k_len,
    output a_out, b_out, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers A (NxK) and B (KxN) and streams them diagonally skewed into an
// output-stationary PE array, then flushes with zeros and pulses done.
module systolic_feeder #(
  parameter int unsigned N = 2,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);
  localparam int unsigned NK  = N * K;
  localparam int unsigned AW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned KW  = $clog2(K + 1);
  localparam int unsigned CW  = $clog2(K + 2 * N + 1);
  localparam int          F   = 2 * int'(N) - 2;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [KW-1:0]  r_klen, w_klen_nxt, w_klen_clamp;
  logic [CW-1:0]  w_s_last;
  logic [7:0]     r_mem_a [NK];
  logic [7:0]     r_mem_b [NK];
  logic [N*8-1:0] r_a_out, r_b_out, w_a_nxt, w_b_nxt;
  logic           r_busy, r_done;
  logic           w_idle, w_addr_ok;

  // The FSM runs one cycle ahead of the registered outputs; the externally
  // visible idle window starts only once r_busy has dropped.
  assign w_idle   = (r_state == ST_IDLE) && !r_busy;
  assign w_s_last = CW'(int'(r_klen) + int'(N) - 2);

  if ((2 ** KW) - 1 > K) begin : g_clamp
    assign w_klen_clamp = (bus.k_len > KW'(K)) ? KW'(K) : bus.k_len;
  end else begin : g_noclamp
    assign w_klen_clamp = bus.k_len;
  end

  if ((2 ** AW) > NK) begin : g_addr_chk
    assign w_addr_ok = ({1'b0, bus.wr_addr} < AW1'(NK));
  end else begin : g_addr_all
    assign w_addr_ok = 1'b1;
  end

  // Operand buffers, frozen while a run is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < int'(NK); m++) begin
        r_mem_a[AW'(m)] <= '0;
        r_mem_b[AW'(m)] <= '0;
      end
    end else if (bus.wr_en && w_idle && w_addr_ok) begin
      if (bus.wr_sel) r_mem_b[bus.wr_addr] <= bus.wr_data;
      else            r_mem_a[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_klen  <= w_klen_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_klen_nxt  = r_klen;
    case (r_state)
      ST_IDLE: begin
        if (w_idle && bus.start && (bus.k_len != '0)) begin
          w_state_nxt = ST_STREAM;
          w_cnt_nxt   = '0;
          w_klen_nxt  = w_klen_clamp;
        end
      end
      ST_STREAM: begin
        if (r_cnt == w_s_last) begin
          w_state_nxt = (F == 0) ? ST_IDLE : ST_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (r_cnt == CW'(F - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Lane l at step s carries A[l][s-l] / B[s-l][l] while s-l lies in [0, k_len)
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    if (r_state == ST_STREAM) begin
      for (int l = 0; l < int'(N); l++) begin
        if ((int'(r_cnt) >= l) && (int'(r_cnt) - l < int'(r_klen))) begin
          w_a_nxt[8*l +: 8] = r_mem_a[AW'(l * int'(K) + int'(r_cnt) - l)];
          w_b_nxt[8*l +: 8] = r_mem_b[AW'((int'(r_cnt) - l) * int'(N) + l)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_out <= '0;
      r_b_out <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_a_out <= w_a_nxt;
      r_b_out <= w_b_nxt;
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_IDLE) && r_busy;
    end
  end

  assign bus.a_out = r_a_out;
  assign bus.b_out = r_b_out;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized bench for systolic_feeder: lane streams, handshake
// timing and resulting PE-array products against a matrix-level model.
module tb_systolic_feeder;
  localparam int N  = 2;
  localparam int K  = 4;
  localparam int AW = $clog2(N * K);
  localparam int KW = $clog2(K + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .K(K)) bus ();
  systolic_feeder #(.N(N), .K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int ma [N][K];
  int mb [K][N];
  int pe_c [N][N];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; commits at the following posedge
  task automatic wr(input bit sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = AW'(addr);
    bus.wr_data = 8'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (sel) mb[addr / N][addr % N] = data;
    else     ma[addr / K][addr % K] = data;
  endtask

  task automatic fill_random();
    for (int a = 0; a < N * K; a++) begin
      wr(1'b0, a, int'($urandom_range(0, 255)));
      wr(1'b1, a, int'($urandom_range(0, 255)));
    end
  endtask

  task automatic idle_check(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_a", 32'(bus.a_out), 32'd0);
      chk("idle_b", 32'(bus.b_out), 32'd0);
    end
  endtask

  // Entered at the negedge before edge E (start already driven). Checks every
  // cycle through done, then emulates the PE array on the captured lanes.
  task automatic check_run(input int kl_raw, input bit poke, input int chain_kl);
    int kl, s_len, tot, acc, ref_c, av, bv;
    int ea [N][64];
    int eb [N][64];
    int ha [N][64];
    int hb [N][64];
    logic [N*8-1:0] va, vb;
    kl    = (kl_raw > K) ? K : kl_raw;
    s_len = kl + N - 1;
    tot   = s_len + (2 * N - 2) + 1;
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 64; t++) begin
        ea[i][t] = 0; eb[i][t] = 0; ha[i][t] = 0; hb[i][t] = 0;
      end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < kl; k++) begin
        ea[i][i + k] = ma[i][k];
        eb[i][i + k] = mb[k][i];
      end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("latency_busy", 32'(bus.busy), 32'd0);
    chk("latency_a", 32'(bus.a_out), 32'd0);
    for (int c = 1; c <= tot; c++) begin
      if (poke && c == 2) begin
        bus.start   = 1'b1;
        bus.k_len   = KW'(3);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 8'd99;
      end else if (poke && c == 3) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      va = '0;
      vb = '0;
      for (int i = 0; i < N; i++) begin
        va[8*i +: 8] = 8'(ea[i][c - 1]);
        vb[8*i +: 8] = 8'(eb[i][c - 1]);
        ha[i][c - 1] = int'(bus.a_out[8*i +: 8]);
        hb[i][c - 1] = int'(bus.b_out[8*i +: 8]);
      end
      chk($sformatf("a_out_c%0d", c), 32'(bus.a_out), 32'(va));
      chk($sformatf("b_out_c%0d", c), 32'(bus.b_out), 32'(vb));
      chk($sformatf("busy_c%0d", c), 32'(bus.busy), 32'(c < tot));
      chk($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == tot));
    end
    if (chain_kl > 0) begin
      bus.start = 1'b1;
      bus.k_len = KW'(chain_kl);
    end
    // PE(i,j) sees a-lane i delayed by j and b-lane j delayed by i
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int t = 0; t < tot + 2 * N; t++) begin
          av = (t - j >= 0 && t - j < 64) ? ha[i][t - j] : 0;
          bv = (t - i >= 0 && t - i < 64) ? hb[j][t - i] : 0;
          acc += av * bv;
        end
        ref_c = 0;
        for (int k = 0; k < kl; k++) ref_c += ma[i][k] * mb[k][j];
        chk($sformatf("pe_c%0d%0d", i, j), 32'(acc), 32'(ref_c));
        pe_c[i][j] = acc;
      end
  endtask

  task automatic go(input int kl, input bit poke, input int chain_kl);
    bus.start = 1'b1;
    bus.k_len = KW'(kl);
    check_run(kl, poke, chain_kl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.k_len = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a", 32'(bus.a_out), 32'd0);
    chk("rst_b", 32'(bus.b_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Basic 2x2 product
    wr(1'b0, 0, 1); wr(1'b0, 1, 2); wr(1'b0, 4, 3); wr(1'b0, 5, 4);
    wr(1'b1, 0, 5); wr(1'b1, 1, 6); wr(1'b1, 2, 7); wr(1'b1, 3, 8);
    go(2, 1'b0, 0);
    chk("basic_c00", 32'(pe_c[0][0]), 32'd19);
    chk("basic_c01", 32'(pe_c[0][1]), 32'd22);
    chk("basic_c10", 32'(pe_c[1][0]), 32'd43);
    chk("basic_c11", 32'(pe_c[1][1]), 32'd50);
    idle_check(2);

    // Full depth, all-ones buffers
    for (int a = 0; a < N * K; a++) begin
      wr(1'b0, a, 1);
      wr(1'b1, a, 1);
    end
    go(4, 1'b0, 0);
    idle_check(1);

    // Clamp above K, and k_len = 0 ignored
    fill_random();
    go(7, 1'b0, 0);
    idle_check(1);
    bus.start = 1'b1;
    bus.k_len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    idle_check(6);

    // Start and write during a run are ignored; old A[0][0] survives
    go(3, 1'b1, 0);
    idle_check(4);
    go(3, 1'b0, 0);
    idle_check(1);

    // Write and start in the same cycle: run sees the new value
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = AW'(4); bus.wr_data = 8'd200;
    ma[1][0] = 200;
    go(2, 1'b0, 0);
    idle_check(1);

    // Back-to-back: start held in the done cycle
    go(2, 1'b0, 4);
    check_run(4, 1'b0, 0);
    idle_check(1);

    // Randomized runs
    repeat (6) begin
      fill_random();
      go(int'($urandom_range(1, 7)), 1'b0, 0);
      idle_check(1);
    end

    // Reset mid-stream aborts and clears the buffers
    fill_random();
    bus.start = 1'b1;
    bus.k_len = KW'(4);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a", 32'(bus.a_out), 32'd0);
    chk("midrst_b", 32'(bus.b_out), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        ma[i][k] = 0;
        mb[k][i] = 0;
      end
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(6);
    go(4, 1'b0, 0);
    idle_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the output-stationary PE array. It buffers an N×K operand matrix A and a K×N matrix B. On `start` it streams them into the array's west edge (A rows) and north edge (B columns) with the diagonal skew the array needs, so that PE(i,j) sees A[i][k] and B[k][j] in the same cycle. It then drives zeros for long enough that the far corner PE finishes accumulating, and reports completion.

## Interface
Parameters:
- `N`, default 2: array dimension, equal to the number of A lanes and the number of B lanes.
- `K`, default 4: maximum inner dimension held in the buffers.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: buffer write strobe.
- `wr_sel` in 1: buffer select; 0 = A, 1 = B.
- `wr_addr` in clog2(N*K): A address is i*K+k; B address is k*N+j.
- `wr_data` in 8: operand byte.
- `start` in 1: request a streaming run.
- `k_len` in clog2(K+1): inner dimension for this run.
- `a_out` out N*8: lane i is bits [8i+7:8i] and drives the west edge of array row i.
- `b_out` out N*8: lane j is bits [8j+7:8j] and drives the north edge of array column j.
- `busy` out 1: high during STREAM and FLUSH.
- `done` out 1: one-cycle completion pulse.

## Operation
- Buffers:
  - 2·N·K bytes, all registered.
  - A write with `wr_en`=1 in IDLE commits at the clock edge.
  - Writes while `busy`=1 are ignored; the buffers stay frozen during a run.
  - An address ≥ N*K is ignored.
- `k_len` handling:
  - Latched when `start` is accepted.
  - A value above K is clamped to K.
  - `start` with `k_len`=0 is ignored, and the block stays in IDLE.
- States:
  - IDLE → STREAM when `start`=1 and `k_len`≠0.
  - STREAM → FLUSH after S = k_len+N−1 steps.
  - FLUSH → IDLE after F = 2N−2 cycles, pulsing `done`.
  - If N=1, F=0: STREAM goes directly to IDLE with `done`.
- `start` in STREAM or FLUSH is ignored; there is no queuing.
- Skew rule at step s (0 ≤ s < S):
  - a lane i = A[i][s−i] if 0 ≤ s−i < k_len, else 0.
  - b lane j = B[s−j][j] if 0 ≤ s−j < k_len, else 0.
- All lanes are 0 in IDLE and FLUSH. A zero operand adds nothing to PE accumulators.
- No arithmetic is performed here. Data is passed as 8-bit values; wrap-around of products is the array's concern.
- `start` and a write in the same IDLE cycle: the write commits first, and the run uses the new value.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, state IDLE, all buffer bytes 0, latched `k_len`=0.
- Reset mid-run aborts immediately; no `done` is produced.
- Let E be the edge that samples an accepted `start`:
  - Step s is driven in the cycle that begins at edge E+1+s. All outputs are registered.
  - `busy` rises at E+1 and falls at E+S+F+1.
  - `done`=1 for exactly the cycle that begins at E+S+F+1 = E+k_len+3N−2.
- A new `start` sampled in the `done` cycle is accepted; back-to-back runs have no idle gap.
- Latency from `start` to first lane data is 1 cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-STREAM → all outputs 0 at once, `busy`=0; after release, no `done` and buffers read as zero.
- Basic 2×2 (N=2, K=4): A=[[1,2],[3,4]], B=[[5,6],[7,8]], `k_len`=2, `start` at E.
  - Steps at E+1..E+3: a0 = 1,2,0; a1 = 0,3,4; b0 = 5,7,0; b1 = 0,6,8.
  - E+4, E+5: all lanes 0.
  - `done` at E+6.
  - Driving a 2×2 PE array from these lanes yields C=[[19,22],[43,50]].
- Full depth: `k_len`=4 with all-ones buffers → a0 is 1 at steps 0–3 and a1 is 1 at steps 1–4 (S=5); `done` at E+8.
- Clamp and zero: `k_len`=7 → behaves as 4. `k_len`=0 with `start` → `busy` stays 0 and no `done`.
- Protection: during a run, pulse `start` and write A[0][0]=99 → run unchanged, no second run. The next run, started after `done`, still streams the old value.
- Back-to-back: `start` held high in the `done` cycle → `busy` re-rises the next edge, and the new step 0 appears with no gap.
